// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words out as LANES-bit beats, MSB- or LSB-first per word.
// Optional parity beat when P2S_PARITY_EN is defined.
//
// state | meaning
// IDLE  | no word loaded, in_ready high, ser_data forced to 0
// SHIFT | word loaded, beat cnt_q presented on ser_data
module p2s_serializer #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic [LANES-1:0] ser_data,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int DBEATS = WIDTH / LANES;
`ifdef P2S_PARITY_EN
  localparam int BEATS = DBEATS + 1;
`else
  localparam int BEATS = DBEATS;
`endif
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("p2s_serializer: WIDTH must be at least 2");
  end
  if (WIDTH % LANES != 0) begin : g_bad_lanes
    $error("p2s_serializer: WIDTH must be a multiple of LANES");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             lsb_q, lsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             beat_xfer;
  logic             on_last;
  logic [LANES-1:0] data_beat;
`ifdef P2S_PARITY_EN
  logic             par_q, par_d;
`endif

  assign busy      = (state_q == SHIFT);
  assign ser_valid = busy;
  assign on_last   = (cnt_q == CW'(BEATS - 1));
  assign ser_first = busy && (cnt_q == '0);
  assign ser_last  = busy && on_last;
  // ser_ready -> in_ready is the only input-to-output path; it lets a new word replace the last beat.
  assign in_ready  = !arst && (!busy || (on_last && ser_ready));
  assign accept    = in_valid && in_ready;
  assign beat_xfer = busy && ser_ready;
  assign data_beat = lsb_q ? shift_q[LANES-1:0] : shift_q[WIDTH-1 -: LANES];

  always_comb begin
    ser_data = '0;
    if (busy) begin
`ifdef P2S_PARITY_EN
      ser_data = on_last ? LANES'(par_q) : data_beat;
`else
      ser_data = data_beat;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    lsb_d   = lsb_q;
    cnt_d   = cnt_q;
`ifdef P2S_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      shift_d = in_data;
      lsb_d   = in_lsb_first;
      cnt_d   = '0;
`ifdef P2S_PARITY_EN
      par_d   = ^in_data;
`endif
    end else if (beat_xfer) begin
      if (on_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        shift_d = lsb_q ? (shift_q >> LANES) : (shift_q << LANES);
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      shift_q <= '0;
      lsb_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef P2S_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      lsb_q   <= lsb_d;
      cnt_q   <= cnt_d;
`ifdef P2S_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Directed bench for p2s_serializer: LANES=1, 4 and 2 instances with WIDTH=8.
// Parity-build expectations apply when P2S_PARITY_EN is defined.
module tb_p2s_serializer;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // LANES=1 instance
  logic       v1 = 0, rdy1, l1 = 0, r1 = 1, sv1, sf1, sl1, b1;
  logic [7:0] d1 = 0;
  logic [0:0] sd1;
  // LANES=4 instance
  logic       v4 = 0, rdy4, l4 = 0, r4 = 1, sv4, sf4, sl4, b4;
  logic [7:0] d4 = 0;
  logic [3:0] sd4;
  // LANES=2 instance
  logic       v2 = 0, rdy2, l2 = 0, r2 = 1, sv2, sf2, sl2, b2;
  logic [7:0] d2 = 0;
  logic [1:0] sd2;

  p2s_serializer #(.WIDTH(8), .LANES(1)) u1 (
    .clk(clk), .arst(arst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .in_lsb_first(l1), .ser_valid(sv1), .ser_ready(r1), .ser_data(sd1),
    .ser_first(sf1), .ser_last(sl1), .busy(b1));

  p2s_serializer #(.WIDTH(8), .LANES(4)) u4 (
    .clk(clk), .arst(arst), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .in_lsb_first(l4), .ser_valid(sv4), .ser_ready(r4), .ser_data(sd4),
    .ser_first(sf4), .ser_last(sl4), .busy(b4));

  p2s_serializer #(.WIDTH(8), .LANES(2)) u2 (
    .clk(clk), .arst(arst), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .in_lsb_first(l2), .ser_valid(sv2), .ser_ready(r2), .ser_data(sd2),
    .ser_first(sf2), .ser_last(sl2), .busy(b2));

  typedef struct {
    logic [7:0] w;
    logic       lsb;
    logic [7:0] seq;  // expected bit of beat b at seq[7-b]
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Standalone LANES=1 word from IDLE; optional stall of stall_len cycles at stall_beat.
  task automatic run_u1(input string nm, input logic [7:0] w, input logic lsb, input logic [7:0] seq,
                        input int stall_beat, input int stall_len);
    int cyc;
    v1 = 1; d1 = w; l1 = lsb; r1 = 1;
    #1 chk({nm, " idle in_ready"}, 32'(rdy1), 1);
    tick();
    v1 = 1; d1 = ~w; l1 = ~lsb;
    cyc = 0;
    for (int b = 0; b < 8; b++) begin
      if (b == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          r1 = 0;
          #1;
          chk({nm, " stall data"}, 32'(sd1), 32'(seq[7-b]));
          chk({nm, " stall valid"}, 32'(sv1), 1);
          chk({nm, " stall first/last"}, {30'd0, sf1, sl1}, 0);
          chk({nm, " stall in_ready"}, 32'(rdy1), 0);
          tick();
          cyc++;
        end
        r1 = 1;
      end
      #1;
      chk({nm, " data"}, 32'(sd1), 32'(seq[7-b]));
      chk({nm, " valid"}, 32'(sv1), 1);
      chk({nm, " first"}, 32'(sf1), 32'(b == 0));
      chk({nm, " last"}, 32'(sl1), 32'(b == 7));
      if (b == 7) v1 = 0;
      #0 chk({nm, " in_ready"}, 32'(rdy1), 32'(b == 7));
      tick();
      cyc++;
    end
    v1 = 0;
    #1;
    chk({nm, " cycles"}, 32'(cyc), 32'(8 + ((stall_beat >= 0) ? stall_len : 0)));
    chk({nm, " done busy"}, 32'(b1), 0);
    chk({nm, " done in_ready"}, 32'(rdy1), 1);
    chk({nm, " done data"}, 32'(sd1), 0);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tab[6];
    logic [3:0] e4[2];
    logic [1:0] e2[5];
    int n2;

    tab[0] = '{w: 8'hA5, lsb: 1'b0, seq: 8'b10100101};
    tab[1] = '{w: 8'h01, lsb: 1'b0, seq: 8'b00000001};
    tab[2] = '{w: 8'h80, lsb: 1'b0, seq: 8'b10000000};
    tab[3] = '{w: 8'hFF, lsb: 1'b0, seq: 8'b11111111};
    tab[4] = '{w: 8'h12, lsb: 1'b1, seq: 8'b01001000};
    tab[5] = '{w: 8'hC8, lsb: 1'b1, seq: 8'b00010011};

    // Reset state
    #1;
    chk("reset outputs", {26'd0, sv1, sd1, sf1, sl1, b1, rdy1}, 0);
    chk("reset in_ready u4", 32'(rdy4), 0);
    tick(); tick();
    arst = 0;
    #1 chk("post-reset in_ready", 32'(rdy1), 1);
    chk("post-reset busy", 32'(b1), 0);
    tick();

`ifndef P2S_PARITY_EN
    // Back-to-back stream from the table; next word always offered during the current one
    v1 = 1; d1 = tab[0].w; l1 = tab[0].lsb; r1 = 1;
    #1 chk("b2b first accept ready", 32'(rdy1), 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i + 1 < 6) begin
        d1 = tab[i+1].w; l1 = tab[i+1].lsb;
      end else begin
        v1 = 0;
      end
      for (int b = 0; b < 8; b++) begin
        #1;
        chk($sformatf("b2b w%0d b%0d data", i, b), 32'(sd1), 32'(tab[i].seq[7-b]));
        chk($sformatf("b2b w%0d b%0d valid", i, b), 32'(sv1), 1);
        chk($sformatf("b2b w%0d b%0d busy", i, b), 32'(b1), 1);
        chk($sformatf("b2b w%0d b%0d first", i, b), 32'(sf1), 32'(b == 0));
        chk($sformatf("b2b w%0d b%0d last", i, b), 32'(sl1), 32'(b == 7));
        chk($sformatf("b2b w%0d b%0d in_ready", i, b), 32'(rdy1), 32'(b == 7));
        tick();
      end
    end
    #1 chk("b2b end busy", 32'(b1), 0);
    chk("b2b end in_ready", 32'(rdy1), 1);
    tick();

    // Backpressure: 3 stalled cycles on beat 3 of 0x5A
    run_u1("stall 5A", 8'h5A, 1'b0, 8'b01011010, 3, 3);

    // Reset during beat 4 of 0xF0
    v1 = 1; d1 = 8'hF0; l1 = 0; r1 = 1;
    tick();
    v1 = 0;
    repeat (4) tick();
    #1 chk("pre-reset busy", 32'(b1), 1);
    arst = 1;
    #1 chk("mid reset outputs", {26'd0, sv1, sd1, sf1, sl1, b1, rdy1}, 0);
    tick();
    #1 chk("held reset outputs", {26'd0, sv1, sd1, sf1, sl1, b1, rdy1}, 0);
    arst = 0;
    #1 chk("release in_ready", 32'(rdy1), 1);
    chk("release valid", 32'(sv1), 0);
    tick();
    run_u1("after reset 0F", 8'h0F, 1'b0, 8'b00001111, -1, 0);

    // LANES=4 LSB-first 0x3C, then MSB-first 0xA5
    e4[0] = 4'hC; e4[1] = 4'h3;
    v4 = 1; d4 = 8'h3C; l4 = 1; r4 = 1;
    tick();
    d4 = 8'hA5; l4 = 0;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk($sformatf("u4 3C b%0d data", b), 32'(sd4), 32'(e4[b]));
      chk($sformatf("u4 3C b%0d first/last", b), {30'd0, sf4, sl4}, (b == 0) ? 2 : 1);
      tick();
    end
    v4 = 0;
    e4[0] = 4'hA; e4[1] = 4'h5;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk($sformatf("u4 A5 b%0d data", b), 32'(sd4), 32'(e4[b]));
      chk($sformatf("u4 A5 b%0d first/last", b), {30'd0, sf4, sl4}, (b == 0) ? 2 : 1);
      tick();
    end
    #1 chk("u4 idle valid", 32'(sv4), 0);

    // LANES=2 MSB-first 0xB4
    e2[0] = 2'b10; e2[1] = 2'b11; e2[2] = 2'b01; e2[3] = 2'b00;
    n2 = 4;
    v2 = 1; d2 = 8'hB4; l2 = 0; r2 = 1;
    tick();
    v2 = 0;
    for (int b = 0; b < n2; b++) begin
      #1;
      chk($sformatf("u2 B4 b%0d data", b), 32'(sd2), 32'(e2[b]));
      chk($sformatf("u2 B4 b%0d last", b), 32'(sl2), 32'(b == n2 - 1));
      tick();
    end
    #1 chk("u2 idle busy", 32'(b2), 0);
`else
    // Parity beat, LANES=2: 0x07 -> 00,00,01,11,parity 01 ; 0x03 -> 00,00,00,11,parity 00
    e2[0] = 2'b00; e2[1] = 2'b00; e2[2] = 2'b01; e2[3] = 2'b11; e2[4] = 2'b01;
    v2 = 1; d2 = 8'h07; l2 = 0; r2 = 1;
    tick();
    d2 = 8'h03;
    for (int b = 0; b < 5; b++) begin
      #1;
      chk($sformatf("par 07 b%0d data", b), 32'(sd2), 32'(e2[b]));
      chk($sformatf("par 07 b%0d first", b), 32'(sf2), 32'(b == 0));
      chk($sformatf("par 07 b%0d last", b), 32'(sl2), 32'(b == 4));
      chk($sformatf("par 07 b%0d in_ready", b), 32'(rdy2), 32'(b == 4));
      tick();
    end
    v2 = 0;
    e2[0] = 2'b00; e2[1] = 2'b00; e2[2] = 2'b00; e2[3] = 2'b11; e2[4] = 2'b00;
    for (int b = 0; b < 5; b++) begin
      #1;
      chk($sformatf("par 03 b%0d data", b), 32'(sd2), 32'(e2[b]));
      chk($sformatf("par 03 b%0d last", b), 32'(sl2), 32'(b == 4));
      chk($sformatf("par 03 b%0d valid", b), 32'(sv2), 1);
      tick();
    end
    #1 chk("par idle busy", 32'(b2), 0);
    chk("par idle data", 32'(sd2), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
